// File: rtl/alu_mul_ctrl.sv
// ---------------------------------------------------------------------------
// alu_mul_ctrl
//
// Sequential 16x16 unsigned shift-add multiplier that borrows the shared
// 16-bit ripple ALU as its adder. The CPU execute stage owns the ALU
// whenever o_busy is low. While o_busy is high, this block drives the ALU
// operand and control lines. It folds each returned sum back into a 32-bit
// partial product, one multiplier bit per cycle.
//
// Optional feature macro: ALU_MUL_OVF_EN
//   When defined, adds o_ovf. o_ovf is registered together with o_product
//   and flags a product that does not fit in 16 bits.
//
// Parameters
//   OP_ADD         ALU op code that selects add (default 3'b010)
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   i_start        multiply request, sampled only while idle
//   i_mcand        multiplicand, captured when a start is accepted
//   i_mplier       multiplier, captured when a start is accepted
//   o_busy         high during the 16 iteration cycles
//   o_done         one-cycle pulse when o_product is updated
//   o_product      32-bit result, held until the next completion
//   o_alu_a        ALU operand a (partial-product high word)
//   o_alu_b        ALU operand b (multiplicand or zero)
//   o_alu_cin      ALU carry in, always 0
//   o_alu_ainvert  ALU a-invert, always 0
//   o_alu_bnegate  ALU b-negate, always 0
//   o_alu_op       ALU operation select, always OP_ADD
//   i_alu_result   ALU sum, combinational return in the same cycle
//   i_alu_cout     ALU carry out of bit 15
//   o_ovf          (ALU_MUL_OVF_EN only) product exceeds 16 bits
// ---------------------------------------------------------------------------
module alu_mul_ctrl #(
  parameter logic [2:0] OP_ADD = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [15:0] i_mcand,
  input  logic [15:0] i_mplier,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_product,
  output logic [15:0] o_alu_a,
  output logic [15:0] o_alu_b,
  output logic        o_alu_cin,
  output logic        o_alu_ainvert,
  output logic        o_alu_bnegate,
  output logic [2:0]  o_alu_op,
  input  logic [15:0] i_alu_result,
  input  logic        i_alu_cout
`ifdef ALU_MUL_OVF_EN
  ,
  output logic        o_ovf
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_mc;
  logic [15:0] r_hi;
  logic [15:0] r_lo;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic [31:0] r_product;

  logic        w_calc;
  logic        w_last;
  logic [31:0] w_product_next;

  assign w_calc = (r_state == S_CALC);
  assign w_last = w_calc && (r_cnt == 4'd15);

  // The ALU sum plus its carry, followed by the multiplier bits not yet
  // consumed. This is the partial product shifted right by one. The carry
  // lands in bit 31, so no bit of the sum is lost.
  assign w_product_next = {i_alu_cout, i_alu_result, r_lo[15:1]};

  // Outside CALC, the operand lines rest at zero and the op at add. The
  // execute stage substitutes its own values while busy is low.
  assign o_alu_a       = w_calc ? r_hi : 16'h0000;
  assign o_alu_b       = (w_calc && r_lo[0]) ? r_mc : 16'h0000;
  assign o_alu_cin     = 1'b0;
  assign o_alu_ainvert = 1'b0;
  assign o_alu_bnegate = 1'b0;
  assign o_alu_op      = OP_ADD;

  assign o_busy    = w_calc;
  assign o_done    = r_done;
  assign o_product = r_product;

  // Control FSM. A start is only looked at in IDLE, so a start that arrives
  // mid-operation is dropped rather than queued. DONE always lasts a single
  // cycle, which gives 18 cycles per multiply when start is held high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) r_state <= S_CALC;
        S_CALC:  if (r_cnt == 4'd15) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand capture and shift-add datapath. The operands are captured only
  // when a start is accepted, so later changes on i_mcand/i_mplier have no
  // effect. Each CALC cycle retires one multiplier bit from the bottom of lo,
  // while the product grows in from the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mc  <= 16'h0000;
      r_hi  <= 16'h0000;
      r_lo  <= 16'h0000;
      r_cnt <= 4'd0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_mc  <= i_mcand;
        r_lo  <= i_mplier;
        r_hi  <= 16'h0000;
        r_cnt <= 4'd0;
      end else if (w_calc) begin
        {r_hi, r_lo} <= w_product_next;
        r_cnt        <= r_cnt + 4'd1;
      end
    end
  end

  // The result register and done pulse are loaded on the final CALC edge
  // straight from the shifter output. This makes both valid together during
  // the DONE cycle. A reset mid-operation clears the result, and since the
  // FSM returns to IDLE, no done pulse follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_product <= 32'h0000_0000;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_product <= w_product_next;
      end
    end
  end

`ifdef ALU_MUL_OVF_EN
  logic r_ovf;

  // Overflow means that any bit of the high half of the finished product is
  // set. It is loaded on the same edge as the product and holds alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= |w_product_next[31:16];
    end
  end

  assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_ctrl
//
// Directed bench for alu_mul_ctrl. A behavioural ripple-ALU stand-in closes
// the add loop. Each vector is a hand-computed product. Timing, the reset
// abort, the ignored mid-run start and back-to-back operation are checked
// cycle by cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_mul_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] aluA;
  logic [15:0] aluB;
  logic        aluCin;
  logic        aluAinvert;
  logic        aluBnegate;
  logic [2:0]  aluOp;
  logic [15:0] aluResult;
  logic        aluCout;
  logic        ovf;

  int checkCount;
  int errorCount;

  alu_mul_ctrl #(.OP_ADD(3'b010)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (start),
    .i_mcand      (mcand),
    .i_mplier     (mplier),
    .o_busy       (busy),
    .o_done       (done),
    .o_product    (product),
    .o_alu_a      (aluA),
    .o_alu_b      (aluB),
    .o_alu_cin    (aluCin),
    .o_alu_ainvert(aluAinvert),
    .o_alu_bnegate(aluBnegate),
    .o_alu_op     (aluOp),
    .i_alu_result (aluResult),
    .i_alu_cout   (aluCout)
`ifdef ALU_MUL_OVF_EN
    ,
    .o_ovf        (ovf)
`endif
  );

`ifndef ALU_MUL_OVF_EN
  assign ovf = 1'b0;
`endif

  // Stand-in for the shared 16-bit ALU: a plain unsigned add with carry out.
  assign {aluCout, aluResult} = {1'b0, aluA} + {1'b0, aluB} + {16'h0000, aluCin};

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Runs one multiply from a one-cycle start, then watches 20 cycles after
  // acceptance. The operand inputs are scrambled right after acceptance.
  // Optionally, a second start is injected at cycle injectAt, or reset is
  // pulsed at cycle resetAt (0 disables either).
  task automatic applyStimulus(input string tag, input logic [15:0] a,
                               input logic [15:0] b, input logic [31:0] expProd,
                               input logic expOvf, input int injectAt,
                               input int resetAt);
    int busyCycles = 0;
    int doneCount  = 0;
    int doneAt     = 0;
    int bNonzero   = 0;
    logic [31:0] prodAtDone = 32'h0;
    @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (busy && aluB !== 16'h0000) bNonzero++;
      if (done) begin
        doneCount++;
        doneAt     = c;
        prodAtDone = product;
      end
      if (c == 1) begin
        checkOutput({tag, " alu_op in CALC"}, {29'b0, aluOp}, 32'h2);
        start  = 1'b0;
        mcand  = ~a;
        mplier = ~b;
      end
      if (injectAt != 0 && c == injectAt) begin
        start  = 1'b1;
        mcand  = 16'h0011;
        mplier = 16'h0022;
      end
      if (injectAt != 0 && c == injectAt + 1) start = 1'b0;
      if (resetAt != 0 && c == resetAt + 1) begin
        checkOutput({tag, " busy after reset"}, {31'b0, busy}, 32'h0);
        checkOutput({tag, " product after reset"}, product, 32'h0);
        checkOutput({tag, " ovf after reset"}, {31'b0, ovf}, 32'h0);
        reset = 1'b0;
      end
      if (resetAt != 0 && c == resetAt) reset = 1'b1;
    end
    if (resetAt != 0) begin
      checkOutput({tag, " busy cycles"}, busyCycles, resetAt);
      checkOutput({tag, " no done"}, doneCount, 0);
      checkOutput({tag, " product held 0"}, product, 32'h0);
    end else begin
      checkOutput({tag, " busy cycles"}, busyCycles, 16);
      checkOutput({tag, " done count"}, doneCount, 1);
      checkOutput({tag, " done cycle"}, doneAt, 17);
      checkOutput({tag, " product at done"}, prodAtDone, expProd);
      checkOutput({tag, " product held"}, product, expProd);
`ifdef ALU_MUL_OVF_EN
      checkOutput({tag, " ovf"}, {31'b0, ovf}, {31'b0, expOvf});
`else
      checkOutput({tag, " ovf tie"}, {31'b0, ovf}, {31'b0, expOvf & 1'b0});
`endif
      if (b == 16'h0000) checkOutput({tag, " alu_b zero"}, bNonzero, 0);
    end
    checkOutput({tag, " idle alu_a"}, {16'b0, aluA}, 32'h0);
  endtask

  // Start is held high for 40 cycles with 2x2. Acceptances land every 18
  // cycles, so done must pulse at 17, 35 and 53 after the first one.
  task automatic heldStart();
    int doneCount = 0;
    int doneAt[3] = '{0, 0, 0};
    logic [31:0] doneProd[3] = '{32'h0, 32'h0, 32'h0};
    @(negedge clk);
    mcand  = 16'h0002;
    mplier = 16'h0002;
    start  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 58; c++) begin
      @(negedge clk);
      if (done) begin
        if (doneCount < 3) begin
          doneAt[doneCount]   = c;
          doneProd[doneCount] = product;
        end
        doneCount++;
      end
      if (c == 39) start = 1'b0;
    end
    checkOutput("held done count", doneCount, 3);
    checkOutput("held first done cycle", doneAt[0], 17);
    checkOutput("held second done cycle", doneAt[1], 35);
    checkOutput("held third done cycle", doneAt[2], 53);
    checkOutput("held first product", doneProd[0], 32'h4);
    checkOutput("held second product", doneProd[1], 32'h4);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset  = 1'b1;
    start  = 1'b0;
    mcand  = 16'h0000;
    mplier = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", {31'b0, busy}, 32'h0);
    checkOutput("reset done", {31'b0, done}, 32'h0);
    checkOutput("reset product", product, 32'h0);
    checkOutput("reset alu_a", {16'b0, aluA}, 32'h0);
    checkOutput("reset alu_b", {16'b0, aluB}, 32'h0);
    checkOutput("reset alu ctrl", {29'b0, aluCin, aluAinvert, aluBnegate}, 32'h0);
    checkOutput("reset alu_op", {29'b0, aluOp}, 32'h2);
    checkOutput("reset ovf", {31'b0, ovf}, 32'h0);
    reset = 1'b0;

    applyStimulus("3x5",       16'h0003, 16'h0005, 32'h0000_000F, 1'b0, 0, 0);
    applyStimulus("FFFFxFFFF", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, 0, 0);
    applyStimulus("1234x0",    16'h1234, 16'h0000, 32'h0000_0000, 1'b0, 0, 0);
    applyStimulus("7x9 inject", 16'h0007, 16'h0009, 32'h0000_003F, 1'b0, 5, 0);
    applyStimulus("FFx100 rst", 16'h00FF, 16'h0100, 32'h0000_0000, 1'b0, 0, 8);
    applyStimulus("FFx100",    16'h00FF, 16'h0100, 32'h0000_FF00, 1'b0, 0, 0);
    applyStimulus("FFFFx1",    16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0, 0, 0);
    applyStimulus("ABCDx1234", 16'hABCD, 16'h1234, 32'h0C37_4FA4, 1'b1, 0, 0);
    heldStart();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
